// File: rtl/cybercobra_pkg.sv
// Shared types and defaults for the cybercobra instruction-memory loader.
package cybercobra_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int WORD_W_DEF = 32;
  localparam int BPW = WORD_W_DEF / 8;

  typedef enum logic [2:0] {
    HDR,
    DATA,
    CHK,
    RUN,
    ERR
  } loader_state_t;

endpackage

// File: rtl/imem_word_assembler.sv
// Packs bytes MSB-first into a word; word_valid is a combinational pulse on the last byte.
module imem_word_assembler #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  localparam int BPW   = WORD_W / 8;
  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [CNT_W-1:0] cnt;

  assign word_valid = byte_valid && (cnt == CNT_W'(BPW - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (byte_valid) begin
      cnt <= word_valid ? '0 : cnt + 1'b1;
    end
  end

  // Only the bytes below the incoming one need storing; the last byte arrives live.
  if (WORD_W > 8) begin : g_shift
    logic [WORD_W-9:0] shift;
    assign word = {shift, byte_data};
    always_ff @(posedge clk) begin
      if (rst || clear) begin
        shift <= '0;
      end else if (byte_valid) begin
        shift <= word[WORD_W-9:0];
      end
    end
  end else begin : g_byte
    assign word = byte_data;
  end

endmodule

// File: rtl/imem_loader.sv
// Receives a framed byte stream, writes instruction words from address 0 and
// releases the core from reset only after a matching XOR checksum.
module imem_loader
  import cybercobra_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  input  logic              reload_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [WORD_W-1:0] mem_wdata_o,
  output logic              cpu_rst_o,
  output logic              done_o,
  output logic              err_o,
  output loader_state_t     state_o
);

  loader_state_t     state;
  logic [ADDR_W:0]   n_words;
  logic [ADDR_W:0]   word_cnt;
  logic [ADDR_W:0]   word_cnt_next;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        chk;
  logic              xfer;
  logic              word_valid;
  logic [WORD_W-1:0] word;

  assign xfer          = rx_valid_i && rx_ready_o;
  assign word_cnt_next = word_cnt + 1'b1;
  assign state_o       = state;

  imem_word_assembler #(.WORD_W(WORD_W)) u_asm (
    .clk        (clk_i),
    .rst        (rst_i),
    .clear      (reload_i || (state != DATA)),
    .byte_valid (xfer && (state == DATA)),
    .byte_data  (rx_data_i),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= HDR;
      rx_ready_o  <= 1'b1;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      cpu_rst_o   <= 1'b1;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      n_words     <= '0;
      word_cnt    <= '0;
      wr_addr     <= '0;
      chk         <= '0;
    end else begin
      mem_we_o <= 1'b0;
      if (reload_i) begin
        state      <= HDR;
        rx_ready_o <= 1'b1;
        cpu_rst_o  <= 1'b1;
        done_o     <= 1'b0;
        err_o      <= 1'b0;
        word_cnt   <= '0;
        wr_addr    <= '0;
        chk        <= '0;
      end else begin
        case (state)
          HDR: if (xfer) begin
            // A zero header stands for a full-depth image.
            n_words  <= (rx_data_i == 8'd0) ? (ADDR_W + 1)'(1 << ADDR_W)
                                            : (ADDR_W + 1)'(rx_data_i);
            chk      <= '0;
            word_cnt <= '0;
            wr_addr  <= '0;
            state    <= DATA;
          end
          DATA: begin
            if (xfer) chk <= chk ^ rx_data_i;
            if (word_valid) begin
              mem_we_o    <= 1'b1;
              mem_wdata_o <= word;
              mem_addr_o  <= wr_addr;
              wr_addr     <= wr_addr + 1'b1;
              word_cnt    <= word_cnt_next;
              if (word_cnt_next == n_words) state <= CHK;
            end
          end
          CHK: if (xfer) begin
            rx_ready_o <= 1'b0;
            if (rx_data_i == chk) begin
              state     <= RUN;
              cpu_rst_o <= 1'b0;
              done_o    <= 1'b1;
            end else begin
              state <= ERR;
              err_o <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framed loads, checksum error, gaps, full depth, reset, RUN idle.
module tb_imem_loader;
  import cybercobra_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          reload = 1'b0;
  logic          mem_we;
  logic [7:0]    mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_rst;
  logic          done;
  logic          err;
  loader_state_t state;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // {cycle, addr, data}
  logic [71:0] exp_q[$];
  logic [71:0] got_q[$];
  logic [31:0] frame_w[256];

  imem_loader dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .rx_data_i   (rx_data),
    .rx_valid_i  (rx_valid),
    .rx_ready_o  (rx_ready),
    .reload_i    (reload),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .cpu_rst_o   (cpu_rst),
    .done_o      (done),
    .err_o       (err),
    .state_o     (state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we) got_q.push_back({cyc, mem_addr, mem_wdata});
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_reload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    if (gap > 0) begin
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    rx_data = b;
    rx_valid = 1'b1;
  endtask

  task automatic end_stream();
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  function automatic logic [7:0] frame_xor(input int n);
    logic [7:0] x = 8'h00;
    for (int w = 0; w < n; w++) x = x ^ frame_w[w][31:24] ^ frame_w[w][23:16]
                                      ^ frame_w[w][15:8] ^ frame_w[w][7:0];
    return x;
  endfunction

  // n = 256 is sent as header 0; expected writes land one clock after each word's last byte.
  task automatic send_frame(input int n, input logic [7:0] chk, input int max_gap);
    logic [31:0] w;
    send_byte(8'(n), 0);
    for (int i = 0; i < n; i++) begin
      w = frame_w[i];
      for (int k = 0; k < 4; k++) begin
        send_byte(w[31-8*k -: 8], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
        if (k == 3) exp_q.push_back({cyc + 1, 8'(i), w});
      end
    end
    send_byte(chk, (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    end_stream();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", rx_ready); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", mem_we); end
    total++; if (mem_addr !== 8'h00) begin bad++; $display("FAIL reset_addr got=%h exp=00", mem_addr); end
    total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", mem_wdata); end
    total++; if (cpu_rst !== 1'b1) begin bad++; $display("FAIL reset_cpu_rst got=%b exp=1", cpu_rst); end
    total++; if (done !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL reset_done_err got=%b%b exp=00", done, err); end
    total++; if (state !== HDR) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", state, HDR); end
  endtask

  task automatic test_frame_ok();
    exp_q.delete(); got_q.delete();
    frame_w[0] = 32'h000000AA;
    frame_w[1] = 32'h010000BB;
    send_frame(2, 8'h10, 0);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL ok_done got=%b exp=1", done); end
    total++; if (cpu_rst !== 1'b0) begin bad++; $display("FAIL ok_cpu_rst got=%b exp=0", cpu_rst); end
    total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL ok_ready got=%b exp=0", rx_ready); end
    total++; if (got_q.size() != 2) begin bad++; $display("FAIL ok_wr_count got=%0d exp=2", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL ok_write[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_chk_err();
    do_reload();
    total++; if (cpu_rst !== 1'b1 || rx_ready !== 1'b1) begin bad++; $display("FAIL err_reload got=%b%b exp=11", cpu_rst, rx_ready); end
    exp_q.delete(); got_q.delete();
    send_frame(2, 8'h11, 0);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_flag got=%b exp=1", err); end
    total++; if (cpu_rst !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL err_cpu_rst_done got=%b%b exp=10", cpu_rst, done); end
    total++; if (state !== ERR) begin bad++; $display("FAIL err_state got=%0d exp=%0d", state, ERR); end
    total++; if (got_q.size() != 2) begin bad++; $display("FAIL err_wr_count got=%0d exp=2", got_q.size()); end
    do_reload();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_cleared got=%b exp=0", err); end
    total++; if (state !== HDR || rx_ready !== 1'b1) begin bad++; $display("FAIL err_to_hdr got=%0d/%b exp=%0d/1", state, rx_ready, HDR); end
  endtask

  task automatic test_gaps();
    exp_q.delete(); got_q.delete();
    send_frame(2, 8'h10, 3);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL gaps_done got=%b exp=1", done); end
    total++; if (got_q.size() != 2) begin bad++; $display("FAIL gaps_wr_count got=%0d exp=2", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL gaps_write[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_full_depth();
    do_reload();
    exp_q.delete(); got_q.delete();
    for (int i = 0; i < 256; i++) frame_w[i] = {8'(i), 8'(~i), 8'(i) ^ 8'h5A, 8'h3C + 8'(i)};
    send_frame(256, frame_xor(256), 0);
    repeat (3) @(negedge clk);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL full_done got=%b exp=1", done); end
    total++; if (got_q.size() != 256) begin bad++; $display("FAIL full_wr_count got=%0d exp=256", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL full_write[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] partial[6];
    partial = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    do_reload();
    exp_q.delete(); got_q.delete();
    send_byte(8'h02, 0);
    for (int i = 0; i < 6; i++) send_byte(partial[i], 0);
    end_stream();
    total++; if (got_q.size() != 1) begin bad++; $display("FAIL mid_pre_count got=%0d exp=1", got_q.size()); end
    do_reset();
    @(negedge clk);
    total++; if (state !== HDR || cpu_rst !== 1'b1) begin bad++; $display("FAIL mid_after_rst got=%0d/%b exp=%0d/1", state, cpu_rst, HDR); end
    exp_q.delete(); got_q.delete();
    frame_w[0] = 32'h12345678;
    send_frame(1, 8'h08, 0);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL mid_done got=%b exp=1", done); end
    total++; if (got_q.size() != 1) begin bad++; $display("FAIL mid_wr_count got=%0d exp=1", got_q.size()); end
    if (got_q.size() > 0) begin
      total++;
      if (got_q[0][39:0] !== {8'h00, 32'h12345678}) begin
        bad++; $display("FAIL mid_write got=%h exp=0012345678", got_q[0][39:0]);
      end
    end
  endtask

  task automatic test_run_ignore();
    got_q.delete();
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data = 8'h55;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (rx_ready !== 1'b0 || mem_we !== 1'b0 || done !== 1'b1) begin
        bad++; $display("FAIL run_idle[%0d] ready/we/done got=%b%b%b exp=001", i, rx_ready, mem_we, done);
      end
    end
    rx_valid = 1'b0;
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL run_no_write got=%0d exp=0", got_q.size()); end
    do_reload();
    total++; if (cpu_rst !== 1'b1) begin bad++; $display("FAIL run_reload_cpu_rst got=%b exp=1", cpu_rst); end
    total++; if (rx_ready !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL run_reload_ready_done got=%b%b exp=10", rx_ready, done); end
  endtask

  initial begin
    test_reset();
    test_frame_ok();
    test_chk_err();
    test_gaps();
    test_full_depth();
    test_reset_mid();
    test_run_ignore();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
